// File: rtl/conv_window_mac_if.sv
// Convolution window MAC interface.
// Carries the tap-load bus (sel, d_load, k_load, din, kin), the start/busy
// control pair, the sel_err load-error pulse, and the result valid/ready
// handshake (result, res_valid, res_ready).
//   master: controller / result-writer side (drives loads, start, res_ready)
//   slave : conv_window_mac side (drives busy, sel_err, result, res_valid)
interface conv_window_mac_if #(
  parameter int DW = 8,
  parameter int KW = 8,
  parameter int AW = DW + KW + 4
);
  logic [8:0]           sel;
  logic                 d_load;
  logic                 k_load;
  logic [DW-1:0]        din;
  logic [KW-1:0]        kin;
  logic                 start;
  logic                 busy;
  logic                 sel_err;
  logic signed [AW-1:0] result;
  logic                 res_valid;
  logic                 res_ready;

  modport master (
    output sel, d_load, k_load, din, kin, start, res_ready,
    input  busy, sel_err, result, res_valid
  );

  modport slave (
    input  sel, d_load, k_load, din, kin, start, res_ready,
    output busy, sel_err, result, res_valid
  );
endinterface

// File: rtl/conv_window_mac.sv
// 3x3 convolution window multiply-accumulate.
// Captures data and kernel taps through a one-hot select.
// When both banks are complete, start runs 9 sequential signed MACs.
// The sum is then offered on a valid/ready output.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : conv_window_mac_if slave (loads, start/busy, sel_err, result handshake)
module conv_window_mac #(
  parameter int DW = 8,
  parameter int KW = 8,
  parameter int AW = DW + KW + 4
) (
  input  logic              clk,
  input  logic              rst,
  conv_window_mac_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  state_e               state_q, state_d;
  logic signed [DW-1:0] data_q   [9];
  logic signed [KW-1:0] kernel_q [9];
  logic [8:0]           d_mask_q, k_mask_q;
  logic signed [AW-1:0] acc_q, result_q;
  logic [3:0]           idx_q;
  logic                 res_valid_q, sel_err_q;

  logic                    sel_onehot;
  logic                    window_full;
  logic                    handshake;
  logic signed [DW+KW-1:0] prod;
  logic signed [AW-1:0]    acc_sum;

  // sel & (sel-1) clears the lowest set bit; only a single-bit value leaves zero.
  assign sel_onehot  = (bus.sel != 9'd0) && ((bus.sel & (bus.sel - 9'd1)) == 9'd0);
  assign window_full = (&d_mask_q) && (&k_mask_q);
  assign handshake   = res_valid_q && bus.res_ready;

  // Both operands are signed, so the product is a full signed DW+KW value.
  // The size cast then sign-extends it to AW, or wraps it if AW is overridden smaller.
  assign prod    = data_q[idx_q] * kernel_q[idx_q];
  assign acc_sum = acc_q + AW'(prod);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && window_full) state_d = MAC;
      MAC:     if (idx_q == 4'd8)            state_d = OUT;
      OUT:     if (handshake)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the tap banks are cleared on reset because reset must leave every tap at zero.
      for (int i = 0; i < 9; i++) begin
        data_q[i]   <= '0;
        kernel_q[i] <= '0;
      end
      d_mask_q    <= '0;
      k_mask_q    <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments here so every register samples pre-edge values.
      sel_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((bus.d_load || bus.k_load) && !sel_onehot) sel_err_q <= 1'b1;
          if (sel_onehot) begin
            for (int i = 0; i < 9; i++) begin
              if (bus.sel[i]) begin
                if (bus.d_load) begin
                  data_q[i]   <= bus.din;
                  d_mask_q[i] <= 1'b1;
                end
                if (bus.k_load) begin
                  kernel_q[i] <= bus.kin;
                  k_mask_q[i] <= 1'b1;
                end
              end
            end
          end
          if (state_d == MAC) begin
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_sum;
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd8) begin
            result_q    <= acc_sum;
            res_valid_q <= 1'b1;
          end
        end
        OUT: begin
          // Kernel bank persists across windows; data must be reloaded each window.
          if (handshake) begin
            res_valid_q <= 1'b0;
            d_mask_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.sel_err   = sel_err_q;
  assign bus.result    = result_q;
  assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed self-checking bench for conv_window_mac.
module tb_conv_window_mac;
  localparam int DW = 8;
  localparam int KW = 8;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_mac_if #(.DW(DW), .KW(KW), .AW(AW)) bus ();

  conv_window_mac #(.DW(DW), .KW(KW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.sel       = '0;
    bus.d_load    = 1'b0;
    bus.k_load    = 1'b0;
    bus.din       = '0;
    bus.kin       = '0;
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  task automatic load_tap(input int i, input int d, input int k, input bit dl, input bit kl);
    bus.sel    = 9'(1 << i);
    bus.din    = DW'(d);
    bus.kin    = KW'(k);
    bus.d_load = dl;
    bus.k_load = kl;
    tick();
    check("load_no_sel_err", int'(bus.sel_err), 0);
    bus.d_load = 1'b0;
    bus.k_load = 1'b0;
    bus.sel    = '0;
  endtask

  task automatic load_window(input int d, input int k, input bit kl);
    for (int i = 0; i < 9; i++) load_tap(i, d, k, 1'b1, kl);
  endtask

  // Pulse start and wait (bounded) for res_valid; expects 9 cycles latency.
  task automatic run_window(input string tag, input int exp);
    int cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, int'(bus.busy), 1);
    cyc = 0;
    while (!bus.res_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_result"}, bus.result, exp);
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_valid_clr"}, int'(bus.res_valid), 0);
    check({tag, "_idle"}, int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int seen;

    // Reset state
    rst = 1'b0;
    idle_bus();
    #3;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_valid", int'(bus.res_valid), 0);
    check("rst_result", bus.result, 0);
    check("rst_sel_err", int'(bus.sel_err), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic window: 9 * (1*2) = 18
    load_window(1, 2, 1'b1);
    run_window("t1", 18);
    handshake("t1");

    // Non-one-hot loads: sel_err single-cycle pulse, nothing written
    bus.d_load = 1'b1; bus.k_load = 1'b1; bus.din = 8'd9; bus.kin = 8'd9;
    bus.sel = 9'h000;
    tick();
    check("sel0_err", int'(bus.sel_err), 1);
    bus.d_load = 1'b0; bus.k_load = 1'b0;
    tick();
    check("sel0_err_clr", int'(bus.sel_err), 0);
    bus.d_load = 1'b1; bus.k_load = 1'b1;
    bus.sel = 9'h003;
    tick();
    check("sel3_err", int'(bus.sel_err), 1);
    bus.d_load = 1'b0; bus.k_load = 1'b0; bus.sel = '0;
    tick();
    check("sel3_err_clr", int'(bus.sel_err), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_incomplete", int'(bus.busy), 0);

    // Data-only reload with retained kernel=2 (kernel untouched by bad loads): 18
    load_window(1, 0, 1'b0);
    run_window("t4a", 18);
    // Hold OUT with res_ready=0 while toggling loads and start
    for (int c = 0; c < 5; c++) begin
      bus.d_load = c[0];
      bus.k_load = 1'b1;
      bus.din    = 8'd7;
      bus.kin    = 8'd5;
      bus.sel    = c[0] ? 9'(1 << c) : 9'h003;
      bus.start  = ~c[0];
      tick();
      check("hold_result", bus.result, 18);
      check("hold_valid", int'(bus.res_valid), 1);
      check("hold_no_sel_err", int'(bus.sel_err), 0);
    end
    bus.d_load = 1'b0; bus.k_load = 1'b0; bus.sel = '0; bus.start = 1'b0;
    handshake("t4a");
    // 9 * (3*2) = 54
    load_window(3, 0, 1'b0);
    run_window("t4b", 54);
    handshake("t4b");

    // Extremes: 9*16384 = 147456; 9*(-16256) = -146304
    load_window(-128, -128, 1'b1);
    run_window("t2a", 147456);
    handshake("t2a");
    load_window(127, -128, 1'b1);
    run_window("t2b", -146304);
    handshake("t2b");

    // Async reset while idx=4
    load_window(1, 2, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("pre_rst_busy", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_valid", int'(bus.res_valid), 0);
    check("arst_result", bus.result, 0);
    check("arst_sel_err", int'(bus.sel_err), 0);
    #2;
    rst = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("post_rst_start_ignored", int'(bus.busy), 0);

    // start held high, res_ready high: one result per refilled window (9*3 = 27)
    load_window(1, 3, 1'b1);
    bus.start = 1'b1;
    bus.res_ready = 1'b1;
    pulses = 0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.res_valid) begin
        pulses++;
        seen = bus.result;
      end
    end
    check("t6a_pulses", pulses, 1);
    check("t6a_result", seen, 27);
    check("t6a_idle", int'(bus.busy), 0);
    load_window(1, 0, 1'b0);
    pulses = 0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.res_valid) begin
        pulses++;
        seen = bus.result;
      end
    end
    check("t6b_pulses", pulses, 1);
    check("t6b_result", seen, 27);
    check("t6b_idle", int'(bus.busy), 0);
    idle_bus();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
Consumer end of the convolution control interface. Captures a 3x3 data window and a 3x3 kernel into register banks, using the one-hot 9-bit select plus the d_load/k_load strobes from the controller. On start, it runs a sequential 9-tap signed multiply-accumulate. It then presents the window result on a valid/ready output toward the result writer.

Parameters:
DW, 8, data sample width (signed two's complement)
KW, 8, kernel coefficient width (signed two's complement)
AW, DW+KW+4, accumulator/result width (holds 9 full-scale products without overflow)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
sel  input  9  one-hot tap select; bit i addresses tap i (row-major, 0 = top-left)
d_load  input  1  write din into data tap selected by sel
k_load  input  1  write kin into kernel tap selected by sel
din  input  DW  data sample
kin  input  KW  kernel coefficient
start  input  1  request MAC over current window
busy  output  1  high whenever state != IDLE
sel_err  output  1  one-cycle pulse: load attempted with non-one-hot sel
result  output  AW  signed window sum, registered
res_valid  output  1  result valid
res_ready  input  1  downstream accepts result

Behaviour:
- Reset (rst=0, async): state IDLE; all data/kernel taps, d_mask, k_mask, acc, idx, result, res_valid, sel_err and busy = 0. Reset mid-MAC or mid-OUT aborts the operation with no partial result.
- Loads are sampled only in IDLE. If sel is one-hot and d_load=1, data[i] <= din and d_mask[i] <= 1. If sel is one-hot and k_load=1, kernel[i] <= kin and k_mask[i] <= 1.
- d_load and k_load together write the same index i in the same cycle.
- Reloading an already-filled tap overwrites it.
- If (d_load|k_load) and sel is not one-hot (zero or two or more bits set): no write, and sel_err=1 for exactly the next cycle. sel_err is only generated in IDLE.
- Loads while busy=1 are ignored silently: no write, no sel_err.
- FSM states are IDLE, MAC and OUT.
  - IDLE -> MAC when start=1 and d_mask and k_mask are both 9'h1FF. On that edge: acc <= 0, idx <= 0.
  - start in IDLE with an incomplete mask is ignored; the FSM stays in IDLE.
  - MAC: one product per cycle, acc <= acc + sext(data[idx])*sext(kernel[idx]), idx <= idx+1, for idx 0..8.
  - On the edge that adds idx 8: result <= final sum, res_valid <= 1, state -> OUT.
- Latency: start accepted at edge T; res_valid is first high after edge T+9.
- OUT: result and res_valid are held stable until res_valid & res_ready at a rising edge. On that edge: res_valid <= 0, d_mask <= 0, state -> IDLE.
  - Kernel taps and k_mask persist across windows.
  - Data tap values persist but must be reloaded, because d_mask is cleared.
- start is ignored in MAC and OUT; one accepted start yields exactly one result.
- A load presented on the handshake edge is ignored, since busy=1 at that edge. Loads are accepted from the following cycle.
- Arithmetic: signed two's complement, products sign-extended to AW. With the default AW no overflow is possible. If AW is overridden smaller, results wrap modulo 2^AW.
- busy is combinational from the state register.

Test Plan:
1. Load taps 0..8 (sel=1<<i) with d_load=k_load=1, din=1, kin=2; pulse start -> busy=1, res_valid rises 9 cycles later, result=18, sel_err never pulses.
2. All din=-128, kin=-128; start -> result=147456. Then din=127, kin=-128 -> result=-146304, no wrap at AW=20.
3. d_load with sel=9'h000, then sel=9'h003 -> sel_err single-cycle pulse each time, no tap written, d_mask unchanged. A following start with an incomplete mask -> busy stays 0.
4. Hold res_ready=0 for 5 cycles in OUT while toggling d_load, din and start -> result and res_valid held, no tap change. Raise res_ready -> IDLE next cycle. Reload only data (din=3), start -> result=54 using the retained kernel=2.
5. Assert rst=0 asynchronously while idx=4 in MAC -> busy, res_valid, result and sel_err drop to 0 immediately. After release, start without reload is ignored.
6. Hold start=1 continuously through MAC and OUT with res_ready=1 -> exactly one res_valid pulse per completed window. A new MAC begins only after IDLE is re-entered and d_mask has been refilled.
